// File: rtl/sim_uart_tx_if.sv
// sim_uart_tx_if: single-outstanding MMIO request/response bundle between a
// requester (CPU side, master) and the UART transmit device (slave).
//   req_valid  : request present            (master -> slave)
//   req_ready  : device can take a request  (slave  -> master)
//   req_wen    : 1 = write, 0 = read        (master -> slave)
//   req_addr   : byte offset, [3:2] decoded (master -> slave)
//   req_wdata  : write data, [7:0] used     (master -> slave)
//   resp_valid : response present           (slave  -> master)
//   resp_ready : requester takes response   (master -> slave)
//   resp_rdata : read data, 0 for writes    (slave  -> master)
interface sim_uart_tx_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sim_uart_tx.sv
// sim_uart_tx: memory-mapped UART transmitter using uartlite register offsets.
// Bytes written to TX_FIFO are queued and drained one per uart_valid pulse,
// with DRAIN_GAP idle cycles after every emitted character.
//   clock      : sole clock, rising edge
//   reset      : asynchronous, active-high, clears all state
//   bus        : MMIO request/response port (sim_uart_tx_if.slave)
//   uart_valid : one-cycle pulse, uart_ch carries a character
//   uart_ch    : character byte
module sim_uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_GAP  = 0
) (
  input  logic          clock,
  input  logic          reset,
  sim_uart_tx_if.slave  bus,
  output logic          uart_valid,
  output logic [7:0]    uart_ch
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (DRAIN_GAP > 1) ? $clog2(DRAIN_GAP) : 1;
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'((DRAIN_GAP > 0) ? DRAIN_GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          ovf_r;

  // response channel
  logic          resp_valid_r;
  logic [31:0]   resp_rdata_r;

  // drain FSM
  state_t        state_r;
  state_t        state_s;
  logic [GW-1:0] gap_cnt_r;
  logic [GW-1:0] gap_cnt_s;
  logic          uart_valid_r;
  logic [7:0]    uart_ch_r;

  // decoded request
  logic          accept_s;
  logic [1:0]    sel_s;
  logic          push_req_s;
  logic          flush_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign accept_s   = bus.req_valid && !resp_valid_r;
  assign sel_s      = bus.req_addr[3:2];
  assign push_req_s = accept_s && bus.req_wen && (sel_s == 2'd1);
  assign flush_s    = accept_s && bus.req_wen && (sel_s == 2'd3) && bus.req_wdata[0];
  // Full/empty come from the registered count, so a pop on the same edge
  // never makes room for a push.
  assign full_s     = (count_r == DEPTH_C);
  assign empty_s    = (count_r == {(AW + 1){1'b0}});
  assign push_s     = push_req_s && !full_s;
  assign unused_s   = ^{bus.req_addr[1:0], bus.req_wdata[31:8]};

  assign bus.req_ready  = !resp_valid_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign uart_valid     = uart_valid_r;
  assign uart_ch        = uart_ch_r;

  // Read data mux; STAT reports pre-edge FIFO state
  always_comb begin
    rdata_s = 32'd0;
    if (!bus.req_wen && (sel_s == 2'd2)) begin
      rdata_s = {27'd0, ovf_r, full_s, empty_s, 2'b00};
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Response register: loads on accept, holds until the requester takes it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else if (accept_s) begin
      resp_valid_r <= 1'b1;
      resp_rdata_r <= rdata_s;
    end else if (resp_valid_r && bus.resp_ready) begin
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
    end else begin
      resp_valid_r <= resp_valid_r;
      resp_rdata_r <= resp_rdata_r;
    end
  end

  // Drain FSM next state; a flush on the same edge suppresses any pop.
  // The last GAP cycle takes the IDLE decision directly so the character
  // period is exactly 1+DRAIN_GAP cycles.
  always_comb begin
    state_s   = state_r;
    gap_cnt_s = gap_cnt_r;
    pop_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && !flush_s) begin
          pop_s   = 1'b1;
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (DRAIN_GAP > 0) begin
          gap_cnt_s = GAP_LOAD;
          state_s   = GAP;
        end else if (!empty_s && !flush_s) begin
          pop_s   = 1'b1;
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_r != {GW{1'b0}}) begin
          gap_cnt_s = gap_cnt_r - GW'(1'b1);
          state_s   = GAP;
        end else if (!empty_s && !flush_s) begin
          pop_s   = 1'b1;
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Drain FSM state, gap counter and registered character outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      gap_cnt_r    <= {GW{1'b0}};
      uart_valid_r <= 1'b0;
      uart_ch_r    <= 8'd0;
    end else begin
      state_r      <= state_s;
      gap_cnt_r    <= gap_cnt_s;
      uart_valid_r <= (state_s == EMIT);
      if (pop_s) begin
        uart_ch_r <= mem_r[rd_ptr_r];
      end else begin
        uart_ch_r <= uart_ch_r;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow; flush overrides everything
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      ovf_r    <= 1'b0;
    end else if (flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
      if (push_req_s && full_s) begin
        ovf_r <= 1'b1;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  // FIFO storage write port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else if (push_s && !flush_s) begin
      mem_r[wr_ptr_r] <= bus.req_wdata[7:0];
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

endmodule
